melody_sequencer: RTL
=====================

// Module: melody_sequencer
// PURPOSE
//  Steps through an external song ROM of {pitch, duration} entries and plays each note.
//  For every note it selects a tone divisor and drives an internal programmable divider to produce the square-wave audio_out.
//  Provides play/stop/mute control and holds a silent gap between notes.
//  Sits between game control logic and the speaker pin.
// PARAMETERS
//  TICK_DIV   12_500_000  clock_in cycles per duration tick (250 ms @ 50 MHz)
//  GAP_TICKS  1           silent ticks inserted after every note; 0 = no gap
//  SONG_LEN   16          max ROM entries played (addresses 0..SONG_LEN-1)
//  ADDR_W     4           rom_addr width; SONG_LEN <= 2**ADDR_W
// PORTS
//  clock_in     in   1       system clock, 50 MHz
//  rst_n        in   1       asynchronous active-low reset
//  play         in   1       level; start the song from addr 0 when idle
//  stop         in   1       level; abort playback, highest priority
//  mute         in   1       level; silence output, sequencing continues
//  rom_addr     out  ADDR_W  song ROM address
//  rom_data     in   8       {pitch[7:4], dur[3:0]}; combinational read, valid same cycle
//  divisor_out  out  28      active tone divisor (full period in clocks)
//  tone_en      out  1       1 while an audible note sounds
//  audio_out    out  1       square wave
//  busy         out  1       1 in any state except IDLE
//  done         out  1       one-cycle pulse at song end
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0; divisor_out=0; tone_en=0; audio_out=0; busy=0; done=0; all counters 0.
//  Pitch table (divisor_out): 0=rest(0), 1=C4 191110, 2=D4 170265, 3=E4 151685, 4=F4 143172,
//    5=G4 127551, 6=A4 113636, 7=B4 101239, 8=C5 95556. Codes 9..15 are treated as rest.
//  States: IDLE, LOAD, PLAY, GAP, DONE.
//  IDLE:  play=1 -> LOAD with rom_addr=0. play asserted in cycle N gives divisor_out/tone_en valid in cycle N+2.
//  LOAD (1 cycle): if dur==0 (end marker) or rom_addr==SONG_LEN -> DONE.
//    Otherwise latch pitch and dur, set divisor_out from the table, tone_en = (pitch valid) & ~mute,
//    clear the divider counter -> PLAY.
//  PLAY:  tick counter counts TICK_DIV clocks per tick. After dur ticks (dur*TICK_DIV clocks in PLAY),
//    tone_en=0, rom_addr+1 -> GAP; if GAP_TICKS==0, go straight to LOAD.
//  GAP:   silent for GAP_TICKS*TICK_DIV clocks -> LOAD.
//  DONE:  done=1 for one cycle; rom_addr=0 -> IDLE.
//  Tick counter clears on every entry to PLAY or GAP. No partial ticks carry across notes.
//  Divider: 28-bit counter, wraps at divisor_out-1; audio_out = (cnt < divisor_out/2) & tone_en, registered.
//    Divisor 0: audio_out held 0.
//  mute: tone_en and audio_out forced 0 on the next cycle; timing and address are unaffected.
//    When mute is released mid-note, the tone resumes on the next cycle.
//  stop=1 in any state -> IDLE next cycle; tone_en=0, audio_out=0, rom_addr=0; no done pulse.
//    stop takes precedence over play in the same cycle.
//  play while busy is ignored. play held high after DONE restarts the song (IDLE -> LOAD).
//  Asserting reset mid-note clears everything immediately (async).
// CONFIGURATION
//  Macro MELODY_LOOP_EN.
//  Defined: at the end condition DONE still pulses done for one cycle, then goes to LOAD at addr 0.
//    The song loops until stop is asserted.
//  Undefined: DONE -> IDLE as described above.
// TESTING (TICK_DIV=4, GAP_TICKS=1, SONG_LEN=16)
//  1. ROM[0]=0x12, ROM[1]=0x00; play pulse -> divisor_out=191110, tone_en=1 for 8 clks;
//     then 4-clk gap; then done pulse; busy=0.
//  2. Divider check with ROM[0]=0x62 (divisor 113636, forced to 8 in a sim shadow table):
//     audio_out shows 4 high / 4 low clocks.
//  3. ROM[0]=0x03 (rest): tone_en=0 and audio_out=0 for 12 clks; rom_addr advances to 1.
//  4. stop asserted in the 3rd clk of PLAY -> next cycle busy=0, rom_addr=0, tone_en=0, no done.
//  5. mute held during ROM[0]=0x12 -> audio_out=0 throughout; done arrives at the same cycle as in test 1.
//  6. ROM all 0x11 -> stops after 16 notes (addr==SONG_LEN) with done.
//     With MELODY_LOOP_EN: loops back to addr 0 until stop.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a {pitch,dur} song ROM, drives a tone divider and a square-wave output.
// Optional feature macro MELODY_LOOP_EN: after the end condition, restart at address 0 instead of idling.
module melody_sequencer #(
   parameter int unsigned TICK_DIV         = 12_500_000,
   parameter int unsigned GAP_TICKS        = 1,
   parameter int unsigned SONG_LEN         = 16,
   parameter int unsigned ADDR_W           = 4,
   // nonzero replaces the divider period of every audible note; divisor_out keeps the table value
   parameter logic [27:0] SIM_DIV_OVERRIDE = '0
) (
   input  logic              clock_in,
   input  logic              rst_n,
   input  logic              play,
   input  logic              stop,
   input  logic              mute,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [27:0]       divisor_out,
   output logic              tone_en,
   output logic              audio_out,
   output logic              busy,
   output logic              done
);
   localparam int unsigned TW  = $clog2(TICK_DIV + 1);
   localparam int unsigned NW  = $clog2(GAP_TICKS + 16);
   localparam int unsigned AW1 = ADDR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW1-1:0]  addr_q, addr_d;
   logic [27:0]     div_q, div_d;
   logic [27:0]     dcnt_q, dcnt_d;
   logic [3:0]      dur_q, dur_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [NW-1:0]   tnum_q, tnum_d;
   logic            tone_q, tone_d;
   logic            audio_q, audio_d;

   logic [3:0]      pitch, dur_in;
   logic [27:0]     tbl_div, period, period_nxt;
   logic            tick_end, note_end, gap_end;

   function automatic logic [27:0] eff_period(input logic [27:0] d);
      return (d != '0 && SIM_DIV_OVERRIDE != '0) ? SIM_DIV_OVERRIDE : d;
   endfunction

   assign pitch  = rom_data[7:4];
   assign dur_in = rom_data[3:0];

   always_comb begin
      case (pitch)
         4'd1:    tbl_div = 28'd191110;
         4'd2:    tbl_div = 28'd170265;
         4'd3:    tbl_div = 28'd151685;
         4'd4:    tbl_div = 28'd143172;
         4'd5:    tbl_div = 28'd127551;
         4'd6:    tbl_div = 28'd113636;
         4'd7:    tbl_div = 28'd101239;
         4'd8:    tbl_div = 28'd95556;
         default: tbl_div = '0;
      endcase
   end

   assign period   = eff_period(div_q);
   assign tick_end = (tcnt_q == TW'(TICK_DIV - 1));
   assign note_end = tick_end && (tnum_q == NW'(dur_q - 4'd1));
   assign gap_end  = tick_end && (tnum_q == NW'(GAP_TICKS - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      div_d   = div_q;
      dur_d   = dur_q;
      tone_d  = tone_q;
      dcnt_d  = '0;
      if (tick_end) begin
         tcnt_d = '0;
         tnum_d = tnum_q + NW'(1);
      end else begin
         tcnt_d = tcnt_q + TW'(1);
         tnum_d = tnum_q;
      end

      case (state_q)
         S_IDLE: begin
            tcnt_d = '0;
            tnum_d = '0;
            if (play) begin
               state_d = S_LOAD;
               addr_d  = '0;
            end
         end
         S_LOAD: begin
            tcnt_d = '0;
            tnum_d = '0;
            if (dur_in == 4'd0 || addr_q == AW1'(SONG_LEN)) begin
               state_d = S_DONE;
               div_d   = '0;
               tone_d  = 1'b0;
            end else begin
               state_d = S_PLAY;
               div_d   = tbl_div;
               dur_d   = dur_in;
               tone_d  = (tbl_div != '0) && !mute;
            end
         end
         S_PLAY: begin
            if (period != '0 && dcnt_q != period - 28'd1)
               dcnt_d = dcnt_q + 28'd1;
            tone_d = (div_q != '0) && !mute;
            if (note_end) begin
               tone_d  = 1'b0;
               addr_d  = addr_q + AW1'(1);
               tcnt_d  = '0;
               tnum_d  = '0;
               state_d = (GAP_TICKS == 0) ? S_LOAD : S_GAP;
            end
         end
         S_GAP: begin
            tone_d = 1'b0;
            if (gap_end) begin
               state_d = S_LOAD;
               tcnt_d  = '0;
               tnum_d  = '0;
            end
         end
         S_DONE: begin
            addr_d = '0;
            tcnt_d = '0;
            tnum_d = '0;
`ifdef MELODY_LOOP_EN
            state_d = S_LOAD;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (stop) begin
         state_d = S_IDLE;
         addr_d  = '0;
         div_d   = '0;
         tone_d  = 1'b0;
         tcnt_d  = '0;
         tnum_d  = '0;
         dcnt_d  = '0;
      end

      // audio is registered from next-state values so mute and tone changes land on the same cycle
      period_nxt = eff_period(div_d);
      audio_d    = tone_d && (period_nxt != '0) && (dcnt_d < (period_nxt >> 1));
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         div_q   <= '0;
         dcnt_q  <= '0;
         dur_q   <= '0;
         tcnt_q  <= '0;
         tnum_q  <= '0;
         tone_q  <= 1'b0;
         audio_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         div_q   <= div_d;
         dcnt_q  <= dcnt_d;
         dur_q   <= dur_d;
         tcnt_q  <= tcnt_d;
         tnum_q  <= tnum_d;
         tone_q  <= tone_d;
         audio_q <= audio_d;
      end
   end

   assign rom_addr    = addr_q[ADDR_W-1:0];
   assign divisor_out = div_q;
   assign tone_en     = tone_q;
   assign audio_out   = audio_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);

endmodule
